// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the slave register bank: response codes,
// word-address offset and the write/read channel state encodings.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  localparam int ADDR_LSB = 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_t;

endpackage

// File: rtl/axi_lite_slave_addr_dec.sv
// Combinational address decode: control registers occupy the low half of the
// index space, status words the high half; any higher set bit is unmapped.
module axi_lite_slave_addr_dec
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS       = 8,
  parameter int IDX_W          = $clog2(NUM_REGS)
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic                      is_ctrl,
  output logic                      is_status,
  output logic [IDX_W-1:0]          idx
);

  localparam int HI = ADDR_LSB + IDX_W + 1;

  logic [IDX_W:0] field;
  logic           upper_clear;
  logic           unused_lsb;

  assign field      = addr[ADDR_LSB +: IDX_W+1];
  assign unused_lsb = ^addr[ADDR_LSB-1:0];

  if (AXI_ADDR_WIDTH > HI) begin : g_upper
    assign upper_clear = (addr[AXI_ADDR_WIDTH-1:HI] == '0);
  end else begin : g_no_upper
    assign upper_clear = 1'b1;
  end

  assign is_ctrl   = upper_clear & ~field[IDX_W];
  assign is_status = upper_clear &  field[IDX_W];
  assign idx       = field[IDX_W-1:0];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS RW control registers and NUM_REGS RO status words.
// Optional AXIL_SLAVE_SELFCLR_EN turns register 0 into a one-cycle self-clearing pulse register.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 8
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]        ctrl_regs,
  input  logic [32*NUM_REGS-1:0]        status_in,
  output logic                          wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]   wr_index
);

  localparam int IDX_W = $clog2(NUM_REGS);

  if (AXI_DATA_WIDTH != 32) begin : g_dw_chk
    $error("axi_lite_slave_regs: AXI_DATA_WIDTH must be 32");
  end
  if (NUM_REGS < 2 || NUM_REGS > 64 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_nr_chk
    $error("axi_lite_slave_regs: NUM_REGS must be a power of 2 in 2..64");
  end

  wstate_t wstate_q, wstate_d;
  rstate_t rstate_q, rstate_d;

  logic                      awready_q, wready_q, arready_q;
  logic                      bvalid_q, rvalid_q;
  resp_t                     bresp_q, rresp_q;
  logic [31:0]               rdata_q;
  logic                      aw_held_q, w_held_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]               wdata_q;
  logic [3:0]                wstrb_q;
  logic                      wr_pulse_q;
  logic [IDX_W-1:0]          wr_index_q;
  logic [31:0]               ctrl_q   [NUM_REGS];
  logic [31:0]               status_w [NUM_REGS];

  logic aw_hs, w_hs, ar_hs;
  logic wdec_ctrl, wdec_status, rdec_ctrl, rdec_status;
  logic [IDX_W-1:0] wdec_idx, rdec_idx;
  logic unused_prot;

  assign aw_hs       = S_AXI_AWVALID & awready_q;
  assign w_hs        = S_AXI_WVALID  & wready_q;
  assign ar_hs       = S_AXI_ARVALID & arready_q;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign ctrl_regs[32*i +: 32] = ctrl_q[i];
    assign status_w[i]           = status_in[32*i +: 32];
  end

  axi_lite_slave_addr_dec #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .IDX_W         (IDX_W)
  ) u_wdec (
    .addr     (awaddr_q),
    .is_ctrl  (wdec_ctrl),
    .is_status(wdec_status),
    .idx      (wdec_idx)
  );

  axi_lite_slave_addr_dec #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .IDX_W         (IDX_W)
  ) u_rdec (
    .addr     (S_AXI_ARADDR),
    .is_ctrl  (rdec_ctrl),
    .is_status(rdec_status),
    .idx      (rdec_idx)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:   if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) wstate_d = W_COMMIT;
      W_COMMIT: wstate_d = W_RESP;
      W_RESP:   if (S_AXI_BREADY) wstate_d = W_IDLE;
      default:  wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_RESP;
      R_RESP:  if (S_AXI_RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write channel: capture AW/W independently, commit one cycle later, hold B until BREADY
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) ctrl_q[i] <= '0;
    end else begin
      wr_pulse_q <= 1'b0;
`ifdef AXIL_SLAVE_SELFCLR_EN
      ctrl_q[0] <= '0;
`endif
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q  <= S_AXI_AWADDR;
            aw_held_q <= 1'b1;
          end
          if (w_hs) begin
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
            w_held_q <= 1'b1;
          end
          awready_q <= ~(aw_held_q | aw_hs);
          wready_q  <= ~(w_held_q | w_hs);
        end
        W_COMMIT: begin
          bvalid_q <= 1'b1;
          if (wdec_ctrl) begin
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= 1'b1;
            wr_index_q <= wdec_idx;
            for (int k = 0; k < 4; k++) begin
              if (wstrb_q[k]) ctrl_q[wdec_idx][8*k +: 8] <= wdata_q[8*k +: 8];
            end
          end else if (wdec_status) begin
            bresp_q <= RESP_SLVERR;
          end else begin
            bresp_q <= RESP_DECERR;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Read channel: data captured at the AR handshake and held until RREADY
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            if (rdec_ctrl) begin
              rdata_q <= ctrl_q[rdec_idx];
              rresp_q <= RESP_OKAY;
            end else if (rdec_status) begin
              rdata_q <= status_w[rdec_idx];
              rresp_q <= RESP_OKAY;
            end else begin
              rdata_q <= '0;
              rresp_q <= RESP_DECERR;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;
  assign wr_index      = wr_index_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: directed AXI-Lite transactions push
// expected B/R responses; independent monitors pop and compare on each handshake.
module tb_axi_lite_slave_regs;

  localparam int NR = 8;

`ifdef AXIL_SLAVE_SELFCLR_EN
  localparam logic [31:0] REG0_AFTER = 32'h0;
`else
  localparam logic [31:0] REG0_AFTER = 32'h1;
`endif

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic [31:0]       awaddr = '0, araddr = '0, wdata = '0;
  logic [2:0]        awprot = '0, arprot = '0;
  logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic              arvalid = 1'b0, rready = 1'b0;
  logic [3:0]        wstrb = '0;
  logic              awready, wready, bvalid, arready, rvalid;
  logic [1:0]        bresp, rresp;
  logic [31:0]       rdata;
  logic [32*NR-1:0]  ctrl_regs;
  logic [32*NR-1:0]  status_in = '0;
  logic              wr_pulse;
  logic [2:0]        wr_index;

  always #5 clk = ~clk;

  axi_lite_slave_regs #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .NUM_REGS      (NR)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .ctrl_regs    (ctrl_regs),
    .status_in    (status_in),
    .wr_pulse     (wr_pulse),
    .wr_index     (wr_index)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];
  logic [1:0]  b_exp_t;
  logic [33:0] r_exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // B monitor
  always @(negedge clk) begin
    if (aresetn && bvalid && bready) begin
      if (exp_b_q.size() == 0) begin
        chk1("b_unexpected", 1'b1, 1'b0);
      end else begin
        b_exp_t = exp_b_q.pop_front();
        chk("bresp", {30'b0, bresp}, {30'b0, b_exp_t});
      end
    end
  end

  // R monitor
  always @(negedge clk) begin
    if (aresetn && rvalid && rready) begin
      if (exp_r_q.size() == 0) begin
        chk1("r_unexpected", 1'b1, 1'b0);
      end else begin
        r_exp_t = exp_r_q.pop_front();
        chk("rdata", rdata, r_exp_t[31:0]);
        chk("rresp", {30'b0, rresp}, {30'b0, r_exp_t[33:32]});
      end
    end
  end

  // Called at posedge+1. bready_delay < 0: leave the response pending (returns at a negedge).
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp, input int w_lead, input int bready_delay,
                          input int chk_idx, input logic [31:0] chk_val, input logic [31:0] post_val);
    bit aw_done = 0, w_done = 0, aw_issued;
    logic aw_r, w_r;
    int cyc = 0;
    if (bready_delay >= 0) exp_b_q.push_back(resp);
    wdata  = data;
    wstrb  = strb;
    wvalid = 1'b1;
    bready = (bready_delay == 0);
    aw_issued = (w_lead == 0);
    if (aw_issued) begin
      awaddr  = addr;
      awvalid = 1'b1;
    end
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      if (w_lead > 0 && w_done && !aw_issued) begin
        chk1("wready_after_w", wready, 1'b0);
        chk1("awready_before_aw", awready, 1'b1);
      end
      aw_r = awready;
      w_r  = wready;
      @(posedge clk); #1;
      if (awvalid && aw_r) begin awvalid = 1'b0; aw_done = 1; end
      if (wvalid && w_r)   begin wvalid  = 1'b0; w_done  = 1; end
      cyc++;
      if (!aw_issued && cyc >= w_lead) begin
        awaddr    = addr;
        awvalid   = 1'b1;
        aw_issued = 1;
      end
      if (cyc > 30) begin
        chk1("aw_w_handshake_timeout", 1'b1, 1'b0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk1("bvalid_before_commit", bvalid, 1'b0);
    @(negedge clk);
    chk1("bvalid_after_commit", bvalid, 1'b1);
    chk1("wr_pulse", wr_pulse, resp == 2'b00);
    if (resp == 2'b00) chk("wr_index", {29'b0, wr_index}, {29'b0, addr[4:2]});
    chk("reg_at_commit", ctrl_regs[32*chk_idx +: 32], chk_val);
    if (bready_delay < 0) return;
    for (int i = 0; i < bready_delay; i++) begin
      chk1("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", {30'b0, bresp}, {30'b0, resp});
      chk1("awready_hold", awready, 1'b0);
      chk1("wready_hold", wready, 1'b0);
      @(posedge clk); #1;
      if (i == bready_delay - 1) bready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk1("bvalid_cleared", bvalid, 1'b0);
    chk1("awready_back", awready, 1'b1);
    chk1("wready_back", wready, 1'b1);
    chk("reg_after_commit", ctrl_regs[32*chk_idx +: 32], post_val);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] resp, input int rready_delay);
    logic ar_r;
    int cyc = 0;
    exp_r_q.push_back({resp, exp_data});
    araddr  = addr;
    arvalid = 1'b1;
    rready  = (rready_delay == 0);
    while (1) begin
      @(negedge clk);
      ar_r = arready;
      @(posedge clk); #1;
      cyc++;
      if (ar_r) begin
        arvalid = 1'b0;
        break;
      end
      if (cyc > 30) begin
        chk1("ar_handshake_timeout", 1'b1, 1'b0);
        arvalid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk1("rvalid_after_ar", rvalid, 1'b1);
    for (int i = 0; i < rready_delay; i++) begin
      chk1("rvalid_hold", rvalid, 1'b1);
      chk("rdata_hold", rdata, exp_data);
      chk("rresp_hold", {30'b0, rresp}, {30'b0, resp});
      chk1("arready_hold", arready, 1'b0);
      @(posedge clk); #1;
      if (i == rready_delay - 1) rready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    chk1("rvalid_cleared", rvalid, 1'b0);
    chk1("arready_back", arready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_awready"}, awready, 1'b0);
    chk1({tag, "_wready"}, wready, 1'b0);
    chk1({tag, "_arready"}, arready, 1'b0);
    chk1({tag, "_bvalid"}, bvalid, 1'b0);
    chk1({tag, "_rvalid"}, rvalid, 1'b0);
    chk1({tag, "_wr_pulse"}, wr_pulse, 1'b0);
    chk1({tag, "_ctrl_any"}, |ctrl_regs, 1'b0);
    chk({tag, "_rdata"}, rdata, 32'h0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    chk1("awready_pre_edge", awready, 1'b0);
    @(negedge clk);
    chk1("awready_up", awready, 1'b1);
    chk1("wready_up", wready, 1'b1);
    chk1("arready_up", arready, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    status_in[63:32] = 32'hCAFE0001;
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    release_reset();

    // Same-cycle AW/W to reg 1, then read back
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF);
    do_read(32'h04, 32'hDEADBEEF, 2'b00, 0);

    // W leads AW by 3 cycles, partial strobe into reg 2
    do_write(32'h08, 32'h11223344, 4'b0101, 2'b00, 3, 0, 2, 32'h00220044, 32'h00220044);
    do_read(32'h08, 32'h00220044, 2'b00, 0);

    // Zero strobe: OKAY, no change
    do_write(32'h04, 32'h00000000, 4'h0, 2'b00, 0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF);

    // Status and unmapped regions
    do_write(32'h20, 32'h12345678, 4'hF, 2'b10, 0, 0, 0, 32'h0, 32'h0);
    do_read(32'h24, 32'hCAFE0001, 2'b00, 0);
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 2'b11, 0, 0, 0, 32'h0, 32'h0);
    do_read(32'h40, 32'h00000000, 2'b11, 0);

    // Back-pressure on B and R
    do_write(32'h0C, 32'h5A5A5A5A, 4'hF, 2'b00, 0, 5, 3, 32'h5A5A5A5A, 32'h5A5A5A5A);
    do_read(32'h0C, 32'h5A5A5A5A, 2'b00, 5);

    // Register 0: pulse register when the self-clear build is selected
    do_write(32'h00, 32'h00000001, 4'hF, 2'b00, 0, 0, 0, 32'h1, REG0_AFTER);
    do_read(32'h00, REG0_AFTER, 2'b00, 0);

    // Reset while a write response is pending
    do_write(32'h10, 32'h77777777, 4'hF, 2'b00, 0, -1, 4, 32'h77777777, 32'h77777777);
    @(posedge clk); #1;
    aresetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    release_reset();
    do_read(32'h10, 32'h00000000, 2'b00, 0);
    do_read(32'h04, 32'h00000000, 2'b00, 0);

    repeat (3) @(posedge clk);
    chk("b_queue_left", exp_b_q.size(), 32'd0);
    chk("r_queue_left", exp_r_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
